// File: rtl/l2_pkg.sv
// Shared widths and FSM state encodings for the direct-mapped write-back L2 cache.
package l2_pkg;

    localparam int unsigned LINE_W = 128;
    localparam int unsigned ADDR_W = 28;

    typedef logic [1:0] l2_state_t;

    localparam l2_state_t IDLE = 2'd0;
    localparam l2_state_t WB   = 2'd1;
    localparam l2_state_t FILL = 2'd2;
    localparam l2_state_t RESP = 2'd3;

endpackage

// File: rtl/l2_line_store.sv
// Data, tag, valid and dirty arrays of the L2 cache: one combinational read port and
// one synchronous write port; valid/dirty clear on reset.
module l2_line_store
    import l2_pkg::*;
#(
    parameter int unsigned NUM_OF_SET = 64,
    parameter int unsigned IDX        = $clog2(NUM_OF_SET),
    parameter int unsigned TAG        = ADDR_W - IDX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX-1:0]    rd_idx,
    output logic [LINE_W-1:0] rd_data,
    output logic [TAG-1:0]    rd_tag,
    output logic              rd_valid,
    output logic              rd_dirty,
    input  logic              wr_en,
    input  logic [IDX-1:0]    wr_idx,
    input  logic [LINE_W-1:0] wr_data,
    input  logic [TAG-1:0]    wr_tag,
    input  logic              wr_valid,
    input  logic              wr_dirty
);

    logic [LINE_W-1:0]     data_q [NUM_OF_SET];
    logic [TAG-1:0]        tag_q  [NUM_OF_SET];
    logic [NUM_OF_SET-1:0] valid_q;
    logic [NUM_OF_SET-1:0] dirty_q;

    assign rd_data  = data_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];

    // Payload arrays need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_idx] <= wr_data;
            tag_q[wr_idx]  <= wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_valid;
            dirty_q[wr_idx] <= wr_dirty;
        end
    end

endmodule

// File: rtl/l2_cache.sv
// Direct-mapped write-back L2 cache between the L1 Dcache and main memory.
// Defining L2_PERF_CNT_EN adds the hit_cnt / miss_cnt performance counters.
module l2_cache
    import l2_pkg::*;
#(
    parameter int unsigned NUM_OF_SET = 64
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              l1_read,
    input  logic              l1_write,
    input  logic [ADDR_W-1:0] l1_addr,
    input  logic [LINE_W-1:0] l1_wdata,
    output logic [LINE_W-1:0] l1_rdata,
    output logic              l1_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef L2_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int unsigned IDX = $clog2(NUM_OF_SET);
    localparam int unsigned TAG = ADDR_W - IDX;

    l2_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              is_read_q, is_read_d;

    logic [LINE_W-1:0] rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              ready_d, mem_read_d, mem_write_d;

    logic [LINE_W-1:0] rd_data;
    logic [TAG-1:0]    rd_tag;
    logic              rd_valid, rd_dirty;

    logic              st_we, st_valid, st_dirty;
    logic [IDX-1:0]    st_idx;
    logic [LINE_W-1:0] st_data;
    logic [TAG-1:0]    st_tag;

    logic              l1_req, hit;

    l2_line_store #(
        .NUM_OF_SET (NUM_OF_SET),
        .IDX        (IDX),
        .TAG        (TAG)
    ) u_store (
        .clk      (clk),
        .reset    (proc_reset),
        .rd_idx   (l1_addr[IDX-1:0]),
        .rd_data  (rd_data),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .wr_en    (st_we),
        .wr_idx   (st_idx),
        .wr_data  (st_data),
        .wr_tag   (st_tag),
        .wr_valid (st_valid),
        .wr_dirty (st_dirty)
    );

    // Read and write together is not a legal request and is left unserved.
    assign l1_req = l1_read ^ l1_write;
    assign hit    = rd_valid && (rd_tag == l1_addr[ADDR_W-1:IDX]);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_read_d   = is_read_q;
        rdata_d     = l1_rdata;
        ready_d     = 1'b0;
        mem_read_d  = mem_read;
        mem_write_d = mem_write;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        st_we       = 1'b0;
        st_idx      = addr_q[IDX-1:0];
        st_data     = wdata_q;
        st_tag      = addr_q[ADDR_W-1:IDX];
        st_valid    = 1'b1;
        st_dirty    = 1'b1;

        case (state_q)
            IDLE: begin
                if (l1_req) begin
                    addr_d    = l1_addr;
                    wdata_d   = l1_wdata;
                    is_read_d = l1_read;
                    st_idx    = l1_addr[IDX-1:0];
                    st_data   = l1_wdata;
                    st_tag    = l1_addr[ADDR_W-1:IDX];
                    if (hit) begin
                        ready_d = 1'b1;
                        state_d = RESP;
                        if (l1_read) begin
                            rdata_d = rd_data;
                        end else begin
                            st_we = 1'b1;
                        end
                    end else if (rd_valid && rd_dirty) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = {rd_tag, l1_addr[IDX-1:0]};
                        mem_wdata_d = rd_data;
                        state_d     = WB;
                    end else if (l1_read) begin
                        mem_read_d = 1'b1;
                        mem_addr_d = l1_addr;
                        state_d    = FILL;
                    end else begin
                        // Whole-line write: install without fetching.
                        st_we   = 1'b1;
                        ready_d = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            WB: begin
                if (mem_ready) begin
                    mem_write_d = 1'b0;
                    st_we       = 1'b1;
                    if (is_read_q) begin
                        // Victim copy stays resident but clean until the fill replaces it.
                        st_data    = mem_wdata;
                        st_tag     = mem_addr[ADDR_W-1:IDX];
                        st_dirty   = 1'b0;
                        mem_read_d = 1'b1;
                        mem_addr_d = addr_q;
                        state_d    = FILL;
                    end else begin
                        ready_d = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            FILL: begin
                if (mem_ready) begin
                    mem_read_d = 1'b0;
                    st_we      = 1'b1;
                    st_data    = mem_rdata;
                    st_dirty   = 1'b0;
                    rdata_d    = mem_rdata;
                    ready_d    = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_read_q <= 1'b0;
            l1_rdata  <= '0;
            l1_ready  <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_read_q <= is_read_d;
            l1_rdata  <= rdata_d;
            l1_ready  <= ready_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

`ifdef L2_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_q == IDLE && l1_req) begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_cache.sv
// Bench for l2_cache: memory responder plus a set-level cache model and a
// last-written-value reference for read data.
module tb_l2_cache;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         l1_read, l1_write;
    logic [27:0]  l1_addr;
    logic [127:0] l1_wdata, l1_rdata;
    logic         l1_ready;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;
`ifdef L2_PERF_CNT_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    l2_cache #(.NUM_OF_SET(64)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .l1_read    (l1_read),
        .l1_write   (l1_write),
        .l1_addr    (l1_addr),
        .l1_wdata   (l1_wdata),
        .l1_rdata   (l1_rdata),
        .l1_ready   (l1_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef L2_PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    typedef struct {
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } txn_t;

    txn_t         seen_q[$];
    txn_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           mem_lat = 3;
    logic [127:0] mem_model [logic [27:0]];
    logic [127:0] ref_val   [logic [27:0]];
    bit           mv [64];
    bit           md [64];
    logic [21:0]  mt [64];
    int           hits_m = 0;
    int           misses_m = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mem_init(input logic [27:0] a);
        if (a == 28'h0000040) return {16{8'hA5}};
        return {4{4'h0, a}} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    endfunction

    function automatic logic [127:0] mem_fetch(input logic [27:0] a);
        return mem_model.exists(a) ? mem_model[a] : mem_init(a);
    endfunction

    function automatic logic [127:0] ref_read(input logic [27:0] a);
        return ref_val.exists(a) ? ref_val[a] : mem_init(a);
    endfunction

    // Main-memory responder: answers each request after mem_lat cycles.
    initial begin
        txn_t t;
        bit   dropped;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!proc_reset && (mem_read || mem_write)) begin
                t.wr   = mem_write;
                t.addr = mem_addr;
                t.data = mem_wdata;
                seen_q.push_back(t);
                dropped = 1'b0;
                for (int i = 1; i < mem_lat; i++) begin
                    @(negedge clk);
                    if (!(mem_read || mem_write)) begin
                        dropped = 1'b1;
                        break;
                    end
                    check("mem_addr stable", mem_addr, t.addr);
                    check("mem_write stable", mem_write, t.wr);
                    if (t.wr) check("mem_wdata stable", mem_wdata, t.data);
                end
                if (!dropped) begin
                    if (t.wr) mem_model[t.addr] = t.data;
                    else mem_rdata = mem_fetch(t.addr);
                    mem_ready = 1'b1;
                    @(negedge clk);
                    mem_ready = 1'b0;
                    if (t.wr) begin
                        check("mem_write drop", mem_write, 1'b0);
                    end else begin
                        check("mem_read drop", mem_read, 1'b0);
                        check("fill ready latency", l1_ready, 1'b1);
                    end
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
        ref_val  = mem_model;
        hits_m   = 0;
        misses_m = 0;
    endtask

    task automatic do_op(input bit rd, input logic [27:0] a, input logic [127:0] wd);
        logic [5:0]  idx;
        logic [21:0] tg;
        bit          hit;
        bit          got;
        int          cyc;
        txn_t        e;
        idx = a[5:0];
        tg  = a[27:6];
        hit = mv[idx] && (mt[idx] == tg);
        exp_q.delete();
        seen_q.delete();
        if (hit) begin
            hits_m++;
        end else begin
            misses_m++;
            if (mv[idx] && md[idx]) begin
                e.wr   = 1'b1;
                e.addr = {mt[idx], idx};
                e.data = ref_read({mt[idx], idx});
                exp_q.push_back(e);
            end
            if (rd) begin
                e.wr   = 1'b0;
                e.addr = a;
                e.data = '0;
                exp_q.push_back(e);
            end
        end
        l1_read  = rd;
        l1_write = !rd;
        l1_addr  = a;
        l1_wdata = wd;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            got = l1_ready;
        end
        l1_read  = 1'b0;
        l1_write = 1'b0;
        check("l1_ready seen", got, 1'b1);
        if (exp_q.size() == 0) check("no-traffic latency", cyc, 1);
        check("mem txn count", seen_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
            check("mem txn dir", seen_q[i].wr, exp_q[i].wr);
            check("mem txn addr", seen_q[i].addr, exp_q[i].addr);
            if (exp_q[i].wr) check("writeback data", seen_q[i].data, exp_q[i].data);
        end
        if (rd) check("l1_rdata", l1_rdata, ref_read(a));
        else ref_val[a] = wd;
        md[idx] = !rd || (hit && md[idx]);
        mv[idx] = 1'b1;
        mt[idx] = tg;
        @(negedge clk);
        check("l1_ready one cycle", l1_ready, 1'b0);
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] d1;
        logic [27:0]  a;
        int           cyc;
        proc_reset = 1'b1;
        l1_read    = 1'b0;
        l1_write   = 1'b0;
        l1_addr    = '0;
        l1_wdata   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset l1_ready", l1_ready, 1'b0);
        check("reset l1_rdata", l1_rdata, '0);
        check("reset mem_read", mem_read, 1'b0);
        check("reset mem_write", mem_write, 1'b0);
        check("reset mem_addr", mem_addr, '0);
        check("reset mem_wdata", mem_wdata, '0);
        proc_reset = 1'b0;
        @(negedge clk);

        // Directed sequence.
        mem_lat = 3;
        do_op(1'b1, 28'h0000040, '0);
        check("cold read A5", l1_rdata, {16{8'hA5}});
        do_op(1'b1, 28'h0000040, '0);
        d = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'h5555_AAAA};
        do_op(1'b0, 28'h0000041, d);
        do_op(1'b1, 28'h0000041, '0);
        check("read back D", l1_rdata, d);
        d1 = {4{32'hC0FF_EE11}};
        do_op(1'b0, 28'h0000042, d1);
        do_op(1'b1, 28'h0001042, '0);

        l1_read  = 1'b1;
        l1_write = 1'b1;
        l1_addr  = 28'h0000040;
        repeat (5) begin
            @(negedge clk);
            check("both high l1_ready", l1_ready, 1'b0);
            check("both high mem", {mem_read, mem_write}, 2'b00);
        end
        l1_read  = 1'b0;
        l1_write = 1'b0;
        @(negedge clk);

        // Randomized traffic over a few sets and tags to force conflicts.
        for (int n = 0; n < 150; n++) begin
            a = {22'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
            mem_lat = $urandom_range(1, 4);
            d = {$urandom, $urandom, $urandom, $urandom};
            do_op(1'($urandom_range(0, 1)), a, d);
        end

        // Reset while a fill is outstanding.
        mem_lat  = 3;
        l1_read  = 1'b1;
        l1_addr  = 28'h0000077;
        cyc = 0;
        while (!mem_read && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("fill started", mem_read, 1'b1);
        proc_reset = 1'b1;
        l1_read    = 1'b0;
        @(negedge clk);
        check("mem_read after reset", mem_read, 1'b0);
        check("mem_write after reset", mem_write, 1'b0);
        proc_reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("l1_ready after reset", l1_ready, 1'b0);
        check("l1_rdata after reset", l1_rdata, '0);
        do_op(1'b1, 28'h0000077, '0);
        do_op(1'b1, 28'h0000077, '0);
        do_op(1'b1, 28'h0000040, '0);
        do_op(1'b1, 28'h0000040, '0);

`ifdef L2_PERF_CNT_EN
        check("hit_cnt", hit_cnt, hits_m);
        check("miss_cnt", miss_cnt, misses_m);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
